// File: rtl/kme_axis_stream_checker.sv
// AXI-stream comparator: joins an actual and an expected stream, compares beat by beat,
// tracks per-TID SoT/EoT framing and keeps sticky status, counters, first-error capture and a stall watchdog.
module kme_axis_stream_checker #(
  parameter int unsigned DWIDTH   = 64,
  parameter int unsigned SWIDTH   = DWIDTH / 8,
  parameter int unsigned UWIDTH   = 8,
  parameter int unsigned TIDW     = 1,
  parameter int unsigned WD_LIMIT = 10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              act_tvalid,
  output logic              act_tready,
  input  logic [DWIDTH-1:0] act_tdata,
  input  logic [SWIDTH-1:0] act_tstrb,
  input  logic [UWIDTH-1:0] act_tuser,
  input  logic [TIDW-1:0]   act_tid,
  input  logic              act_tlast,
  input  logic              exp_tvalid,
  output logic              exp_tready,
  input  logic [DWIDTH-1:0] exp_tdata,
  input  logic [SWIDTH-1:0] exp_tstrb,
  input  logic [UWIDTH-1:0] exp_tuser,
  input  logic [TIDW-1:0]   exp_tid,
  output logic [31:0]       beat_cnt,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       err_cnt,
  output logic [6:0]        err_flags,
  output logic              first_err_valid,
  output logic [31:0]       first_err_beat,
  output logic [6:0]        first_err_flags,
  output logic              busy
);
  localparam int unsigned NCTX = 1 << TIDW;
  localparam int unsigned NFLG = 7;
  localparam logic [UWIDTH-1:0] U_SOT = UWIDTH'(1);
  localparam logic [UWIDTH-1:0] U_EOT = UWIDTH'(2);
  localparam logic [UWIDTH-1:0] U_MID = UWIDTH'(3);

  logic            w_cmp, w_data_mis, w_skip_data, w_frame_err, w_beat_err;
  logic            w_act_sot, w_act_eot, w_act_mid, w_cur_in, w_cur_stats;
  logic            w_wd_inc, w_wd_fire;
  logic [NFLG-1:0] w_beat_flags;
  logic [NCTX-1:0] r_in_frame, r_stats, w_in_frame_nxt, w_stats_nxt;
  logic [31:0]     r_beat_cnt, r_frame_cnt, r_first_err_beat, r_wd_cnt;
  logic [15:0]     r_err_cnt;
  logic [NFLG-1:0] r_err_flags, r_first_err_flags;
  logic            r_first_err_valid, r_busy;

  // Join: each side is ready only when the other side has a beat to pair with.
  assign act_tready = enable & ~clear & exp_tvalid;
  assign exp_tready = enable & ~clear & act_tvalid;
  assign w_cmp      = enable & ~clear & act_tvalid & exp_tvalid;

  always_comb begin
    w_data_mis = 1'b0;
    for (int unsigned i = 0; i < SWIDTH; i++) begin
      if (exp_tstrb[i] && (act_tdata[8*i +: 8] != exp_tdata[8*i +: 8])) w_data_mis = 1'b1;
    end
  end

  assign w_act_sot   = (act_tuser == U_SOT);
  assign w_act_eot   = (act_tuser == U_EOT);
  assign w_act_mid   = (act_tuser == U_MID);
  assign w_cur_in    = r_in_frame[exp_tid];
  assign w_cur_stats = r_stats[exp_tid];
  // Stats frames carry non-deterministic payload on their EoT beat.
  assign w_skip_data = w_cur_stats & (exp_tuser == U_EOT);
  assign w_frame_err = ~(w_act_sot | w_act_eot | w_act_mid)
                     | (w_act_sot & w_cur_in)
                     | ((w_act_mid | w_act_eot) & ~w_cur_in);

  assign w_beat_flags = {1'b0,
                         w_frame_err,
                         act_tid != exp_tid,
                         act_tlast != (exp_tuser == U_EOT),
                         act_tstrb != exp_tstrb,
                         act_tuser != exp_tuser,
                         w_data_mis & ~w_skip_data};
  assign w_beat_err = |w_beat_flags;

  // Watchdog advances only while expected data waits on a silent actual stream.
  assign w_wd_inc  = (WD_LIMIT != 0) & enable & exp_tvalid & ~act_tvalid & (r_wd_cnt != WD_LIMIT);
  assign w_wd_fire = w_wd_inc & (r_wd_cnt == 32'(WD_LIMIT - 1));

  // Context next state: framing follows act_tuser, stats marking follows the expected stream.
  always_comb begin
    w_in_frame_nxt = r_in_frame;
    w_stats_nxt    = r_stats;
    if (clear) begin
      w_in_frame_nxt = '0;
      w_stats_nxt    = '0;
    end else if (w_cmp) begin
      if (w_act_sot)      w_in_frame_nxt[exp_tid] = 1'b1;
      else if (w_act_eot) w_in_frame_nxt[exp_tid] = 1'b0;
      if (exp_tuser == U_SOT)      w_stats_nxt[exp_tid] = (exp_tdata[7:0] == 8'h08);
      else if (exp_tuser == U_EOT) w_stats_nxt[exp_tid] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_frame <= '0;
      r_stats    <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_in_frame <= w_in_frame_nxt;
      r_stats    <= w_stats_nxt;
      r_busy     <= |w_in_frame_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt        <= '0;
      r_frame_cnt       <= '0;
      r_err_cnt         <= '0;
      r_err_flags       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_beat  <= '0;
      r_first_err_flags <= '0;
      r_wd_cnt          <= '0;
    end else if (clear) begin
      r_beat_cnt        <= '0;
      r_frame_cnt       <= '0;
      r_err_cnt         <= '0;
      r_err_flags       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_beat  <= '0;
      r_first_err_flags <= '0;
      r_wd_cnt          <= '0;
    end else if (w_cmp) begin
      r_beat_cnt  <= r_beat_cnt + 32'd1;
      r_wd_cnt    <= '0;
      r_err_flags <= r_err_flags | w_beat_flags;
      if (w_act_eot) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_beat_err) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (!r_first_err_valid) begin
          r_first_err_valid <= 1'b1;
          r_first_err_beat  <= r_beat_cnt;
          r_first_err_flags <= w_beat_flags;
        end
      end
    end else if (w_wd_inc) begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
      if (w_wd_fire) begin
        r_err_flags[6] <= 1'b1;
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (!r_first_err_valid) begin
          r_first_err_valid <= 1'b1;
          r_first_err_beat  <= r_beat_cnt;
          r_first_err_flags <= NFLG'(7'h40);
        end
      end
    end
  end

  assign beat_cnt        = r_beat_cnt;
  assign frame_cnt       = r_frame_cnt;
  assign err_cnt         = r_err_cnt;
  assign err_flags       = r_err_flags;
  assign first_err_valid = r_first_err_valid;
  assign first_err_beat  = r_first_err_beat;
  assign first_err_flags = r_first_err_flags;
  assign busy            = r_busy;
endmodule

// File: tb/tb_kme_axis_stream_checker.sv
// Directed bench for kme_axis_stream_checker: expected status snapshots are queued per driven beat
// and compared one cycle later when the registered results appear.
module tb_kme_axis_stream_checker;
  localparam logic [7:0] SOT = 8'h01;
  localparam logic [7:0] EOT = 8'h02;
  localparam logic [7:0] MID = 8'h03;

  logic        clk, rst_n, enable, clear;
  logic        act_tvalid, act_tready, act_tlast;
  logic [63:0] act_tdata, exp_tdata;
  logic [7:0]  act_tstrb, act_tuser, exp_tstrb, exp_tuser;
  logic [0:0]  act_tid, exp_tid;
  logic        exp_tvalid, exp_tready;
  logic [31:0] beat_cnt, frame_cnt, first_err_beat;
  logic [15:0] err_cnt;
  logic [6:0]  err_flags, first_err_flags;
  logic        first_err_valid, busy;

  kme_axis_stream_checker #(.DWIDTH(64), .SWIDTH(8), .UWIDTH(8), .TIDW(1), .WD_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .act_tvalid(act_tvalid), .act_tready(act_tready), .act_tdata(act_tdata), .act_tstrb(act_tstrb),
    .act_tuser(act_tuser), .act_tid(act_tid), .act_tlast(act_tlast),
    .exp_tvalid(exp_tvalid), .exp_tready(exp_tready), .exp_tdata(exp_tdata), .exp_tstrb(exp_tstrb),
    .exp_tuser(exp_tuser), .exp_tid(exp_tid),
    .beat_cnt(beat_cnt), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .err_flags(err_flags),
    .first_err_valid(first_err_valid), .first_err_beat(first_err_beat),
    .first_err_flags(first_err_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] beat;
    logic [31:0] frame;
    logic [15:0] err;
    logic [6:0]  flags;
    logic        fv;
    logic [31:0] fbeat;
    logic [6:0]  fflags;
    logic        busy;
  } snap_t;

  snap_t q[$];
  int n_cmp, n_err;

  logic [31:0] m_beat, m_frame, m_fbeat;
  logic [15:0] m_err;
  logic [6:0]  m_flags, m_fflags;
  logic        m_fv;
  logic [1:0]  m_inf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic m_reset();
    m_beat = 0; m_frame = 0; m_fbeat = 0; m_err = 0;
    m_flags = 0; m_fflags = 0; m_fv = 0; m_inf = 0;
  endtask

  task automatic check_pop();
    snap_t s;
    chk("sb_depth", 32'(q.size()), 1);
    if (q.size() == 0) return;
    s = q.pop_front();
    chk("beat_cnt", beat_cnt, s.beat);
    chk("frame_cnt", frame_cnt, s.frame);
    chk("err_cnt", 32'(err_cnt), 32'(s.err));
    chk("err_flags", 32'(err_flags), 32'(s.flags));
    chk("first_err_valid", 32'(first_err_valid), 32'(s.fv));
    chk("first_err_beat", first_err_beat, s.fbeat);
    chk("first_err_flags", 32'(first_err_flags), 32'(s.fflags));
    chk("busy", 32'(busy), 32'(s.busy));
  endtask

  // One paired beat; bf is the set of flags this beat is meant to raise.
  task automatic send(input logic [7:0] au, input logic [63:0] ad, input logic [7:0] as_, input logic al,
                      input logic ati, input logic [7:0] eu, input logic [63:0] ed, input logic [7:0] es,
                      input logic eti, input logic [6:0] bf);
    snap_t s;
    act_tvalid = 1'b1; act_tdata = ad; act_tstrb = as_; act_tuser = au; act_tid = ati; act_tlast = al;
    exp_tvalid = 1'b1; exp_tdata = ed; exp_tstrb = es; exp_tuser = eu; exp_tid = eti;
    if (bf != 7'h0) begin
      if (!m_fv) begin m_fv = 1'b1; m_fbeat = m_beat; m_fflags = bf; end
      if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end
    m_flags = m_flags | bf;
    m_beat  = m_beat + 32'd1;
    if (au == EOT) m_frame = m_frame + 32'd1;
    if (au == SOT) m_inf[eti] = 1'b1;
    else if (au == EOT) m_inf[eti] = 1'b0;
    s.beat = m_beat; s.frame = m_frame; s.err = m_err; s.flags = m_flags;
    s.fv = m_fv; s.fbeat = m_fbeat; s.fflags = m_fflags; s.busy = |m_inf;
    q.push_back(s);
    #1;
    chk("act_tready", 32'(act_tready), 1);
    chk("exp_tready", 32'(exp_tready), 1);
    @(posedge clk); @(negedge clk);
    act_tvalid = 1'b0; exp_tvalid = 1'b0;
    check_pop();
  endtask

  task automatic ok(input logic tid, input logic [7:0] u, input logic [63:0] d);
    send(u, d, 8'hFF, u == EOT, tid, u, d, 8'hFF, tid, 7'h00);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    m_reset();
    chk({tag, "_beat"}, beat_cnt, 0);
    chk({tag, "_err"}, 32'(err_cnt), 0);
    chk({tag, "_flags"}, 32'(err_flags), 0);
    chk({tag, "_fv"}, 32'(first_err_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
    act_tvalid = 1'b0; act_tdata = '0; act_tstrb = '0; act_tuser = '0; act_tid = '0; act_tlast = 1'b0;
    exp_tvalid = 1'b0; exp_tdata = '0; exp_tstrb = '0; exp_tuser = '0; exp_tid = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_frame", frame_cnt, 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_flags", 32'(err_flags), 0);
    chk("rst_fv", 32'(first_err_valid), 0);
    chk("rst_fbeat", first_err_beat, 0);
    chk("rst_fflags", 32'(first_err_flags), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_act_tready", 32'(act_tready), 0);
    chk("rst_exp_tready", 32'(exp_tready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // Clean 4-beat frame
    ok(0, SOT, 64'h0706050403020100);
    ok(0, MID, 64'h0F0E0D0C0B0A0908);
    ok(0, MID, 64'h1716151413121110);
    ok(0, EOT, 64'h1F1E1D1C1B1A1918);

    // Byte 3 corrupted on beat 2, strobed vs. unstrobed
    do_clear("clr1");
    ok(0, SOT, 64'hA0A1A2A3A4A5A6A7);
    send(MID, 64'hB0B1B2B3B4B5B6B7 ^ 64'h000000005A000000, 8'hFF, 1'b0, 1'b0,
         MID, 64'hB0B1B2B3B4B5B6B7, 8'hFF, 1'b0, 7'h01);
    ok(0, MID, 64'hC0C1C2C3C4C5C6C7);
    ok(0, EOT, 64'hD0D1D2D3D4D5D6D7);
    chk("t2_first_err_beat", first_err_beat, 1);
    do_clear("clr2");
    ok(0, SOT, 64'hA0A1A2A3A4A5A6A7);
    send(MID, 64'hB0B1B2B3B4B5B6B7 ^ 64'h000000005A000000, 8'hF7, 1'b0, 1'b0,
         MID, 64'hB0B1B2B3B4B5B6B7, 8'hF7, 1'b0, 7'h00);
    ok(0, MID, 64'hC0C1C2C3C4C5C6C7);
    ok(0, EOT, 64'hD0D1D2D3D4D5D6D7);

    // Stats frames: EoT data ignored, tlast still checked; non-stats frame still data-checked
    do_clear("clr3");
    ok(0, SOT, 64'h1111222233334408);
    ok(0, MID, 64'h5555666677778888);
    send(EOT, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1, 1'b0, EOT, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 7'h00);
    ok(0, SOT, 64'h1111222233334408);
    send(EOT, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b0, 1'b0, EOT, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 7'h08);
    ok(0, SOT, 64'h1111222233334407);
    send(EOT, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1, 1'b0, EOT, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 7'h01);

    // Interleaved TIDs, then per-field mismatches and framing violations
    do_clear("clr4");
    ok(0, SOT, 64'h00000000000000A0);
    ok(1, SOT, 64'h00000000000000B0);
    ok(0, MID, 64'h00000000000000A1);
    ok(1, MID, 64'h00000000000000B1);
    ok(0, EOT, 64'h00000000000000A2);
    ok(1, EOT, 64'h00000000000000B2);
    send(MID, 64'h55, 8'hFF, 1'b0, 1'b0, MID, 64'h55, 8'hFF, 1'b0, 7'h20);
    send(SOT, 64'h66, 8'hFF, 1'b0, 1'b1, SOT, 64'h66, 8'hFF, 1'b0, 7'h10);
    ok(0, EOT, 64'h77);
    send(SOT, 64'h88, 8'hFF, 1'b0, 1'b0, MID, 64'h88, 8'hFF, 1'b0, 7'h02);
    send(EOT, 64'h99, 8'hFF, 1'b1, 1'b0, EOT, 64'h99, 8'h0F, 1'b0, 7'h04);
    send(8'h05, 64'hAA, 8'hFF, 1'b0, 1'b0, 8'h05, 64'hAA, 8'hFF, 1'b0, 7'h20);

    // Reset mid-frame: the trailing middle beat is a framing error
    ok(0, SOT, 64'h1234);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    chk("rst_mid_busy", 32'(busy), 0);
    send(MID, 64'h5678, 8'hFF, 1'b0, 1'b0, MID, 64'h5678, 8'hFF, 1'b0, 7'h20);

    // clear while streaming: readies drop, state zeroes, the held beat goes through afterwards
    ok(0, SOT, 64'h01);
    ok(0, MID, 64'h02);
    act_tvalid = 1'b1; act_tdata = 64'h03; act_tstrb = 8'hFF; act_tuser = SOT; act_tid = 1'b0; act_tlast = 1'b0;
    exp_tvalid = 1'b1; exp_tdata = 64'h03; exp_tstrb = 8'hFF; exp_tuser = SOT; exp_tid = 1'b0;
    clear = 1'b1;
    #1;
    chk("clr_act_tready", 32'(act_tready), 0);
    chk("clr_exp_tready", 32'(exp_tready), 0);
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    m_reset();
    chk("clr_s_beat", beat_cnt, 0);
    chk("clr_s_frame", frame_cnt, 0);
    chk("clr_s_err", 32'(err_cnt), 0);
    chk("clr_s_busy", 32'(busy), 0);
    ok(0, SOT, 64'h03);
    ok(0, EOT, 64'h04);

    // Watchdog fires once after 16 stalled cycles
    do_clear("clr5");
    exp_tvalid = 1'b1; act_tvalid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("wd_pre_flags", 32'(err_flags), 0);
    @(posedge clk); @(negedge clk);
    chk("wd_flags", 32'(err_flags), 32'h40);
    chk("wd_err", 32'(err_cnt), 1);
    chk("wd_fv", 32'(first_err_valid), 1);
    chk("wd_fflags", 32'(first_err_flags), 32'h40);
    chk("wd_fbeat", first_err_beat, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wd_err_hold", 32'(err_cnt), 1);
    exp_tvalid = 1'b0;

    // clear coinciding with the watchdog threshold suppresses it
    do_clear("clr6");
    exp_tvalid = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    exp_tvalid = 1'b0;
    chk("wd_clr_flags", 32'(err_flags), 0);
    chk("wd_clr_err", 32'(err_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
